// File: rtl/bpsk_demodulator_pkg.sv
// Shared parameters for the BPSK receive path: sample/carrier geometry and FSM
// states in core_params; lock-detector tuning in network_params.
package core_params;

  localparam int SAMPLE_WIDTH    = 12;
  localparam int SAMPLES_PER_BIT = 16;
  localparam int LUT_WIDTH       = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

package network_params;

  localparam int THRESHOLD  = 2 ** (core_params::SAMPLE_WIDTH + core_params::LUT_WIDTH - 2);
  localparam int LOCK_COUNT = 8;
  localparam int LOSS_COUNT = 4;

endpackage

// File: rtl/bpsk_demodulator_if.sv
// Sample-in / bit-out bundle between the ADC front end, the demodulator and the
// receiver buffer.
interface bpsk_demodulator_if #(
  parameter int SAMPLE_WIDTH = core_params::SAMPLE_WIDTH
);

  logic signed [SAMPLE_WIDTH-1:0] sample;
  logic                           sample_valid;
  logic                           data_stream;
  logic                           read;
  logic                           clear;
  logic                           locked;

  modport master (
    output sample, sample_valid,
    input  data_stream, read, clear, locked
  );

  modport slave (
    input  sample, sample_valid,
    output data_stream, read, clear, locked
  );

endinterface

// File: rtl/carrier_lut.sv
// One-period sine reference, elaborated to constants and indexed by phase.
module carrier_lut #(
  parameter int SAMPLES_PER_BIT = core_params::SAMPLES_PER_BIT,
  parameter int LUT_WIDTH       = core_params::LUT_WIDTH
) (
  input  logic        [$clog2(SAMPLES_PER_BIT)-1:0] phase,
  output logic signed [LUT_WIDTH-1:0]               lut_value
);

  localparam real TWO_PI = 6.283185307179586;
  localparam real AMP    = real'((2 ** (LUT_WIDTH - 1)) - 1);

  logic signed [LUT_WIDTH-1:0] rom [SAMPLES_PER_BIT];

  // Round half away from zero so the table is antisymmetric about pi.
  for (genvar gi = 0; gi < SAMPLES_PER_BIT; gi++) begin : g_rom
    localparam real X = AMP * $sin(TWO_PI * real'(gi) / real'(SAMPLES_PER_BIT));
    localparam int  R = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
    assign rom[gi] = LUT_WIDTH'(R);
  end

  assign lut_value = rom[phase];

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: multiply by carrier, integrate-and-dump per symbol,
// differential decode, and a strong/weak symbol run counter for lock detection.
module bpsk_demodulator #(
  parameter int SAMPLE_WIDTH    = core_params::SAMPLE_WIDTH,
  parameter int SAMPLES_PER_BIT = core_params::SAMPLES_PER_BIT,
  parameter int LUT_WIDTH       = core_params::LUT_WIDTH,
  parameter int THRESHOLD       = network_params::THRESHOLD,
  parameter int LOCK_COUNT      = network_params::LOCK_COUNT,
  parameter int LOSS_COUNT      = network_params::LOSS_COUNT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic                           sample_valid,
  output logic                           data_stream,
  output logic                           read,
  output logic                           clear,
  output logic                           locked
);

  import core_params::state_t;
  import core_params::SEARCH;
  import core_params::LOCKED;

  localparam int PW     = $clog2(SAMPLES_PER_BIT);
  localparam int PROD_W = SAMPLE_WIDTH + LUT_WIDTH;
  localparam int ACC_W  = PROD_W + PW;
  localparam int RUN_W  = $clog2((LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT) + 1;

  localparam logic [PW-1:0]    PHASE_LAST = PW'(SAMPLES_PER_BIT - 1);
  localparam logic [RUN_W-1:0] LOCK_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST  = RUN_W'(LOSS_COUNT - 1);
  localparam logic [ACC_W:0]   THR        = (ACC_W + 1)'(THRESHOLD);

  logic        [PW-1:0]        phase_q;
  logic signed [LUT_WIDTH-1:0] lut_value;
  logic signed [PROD_W-1:0]    product_d;
  logic signed [PROD_W-1:0]    product_q;
  logic                        pvalid_q;
  logic                        plast_q;

  carrier_lut #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .LUT_WIDTH       (LUT_WIDTH)
  ) u_lut (
    .phase     (phase_q),
    .lut_value (lut_value)
  );

  assign product_d = PROD_W'(sample) * PROD_W'(lut_value);

  // Stage 1: mixer. pvalid_q marks a fresh product so stage 2 never re-adds a held one.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      product_q <= '0;
      pvalid_q  <= 1'b0;
      plast_q   <= 1'b0;
    end else begin
      pvalid_q <= sample_valid;
      if (sample_valid) begin
        product_q <= product_d;
        plast_q   <= (phase_q == PHASE_LAST);
        phase_q   <= phase_q + PW'(1);
      end
    end
  end

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_d;
  logic        [ACC_W-1:0] mag_d;
  logic                    dump_q;
  logic                    dec_q;
  logic                    above_q;

  assign sum_d = acc_q + ACC_W'(product_q);
  assign mag_d = sum_d[ACC_W-1] ? ACC_W'(-sum_d) : ACC_W'(sum_d);

  // Stage 2: integrate-and-dump; the symbol verdict is registered with the dump strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      dump_q  <= 1'b0;
      dec_q   <= 1'b0;
      above_q <= 1'b0;
    end else begin
      dump_q <= pvalid_q && plast_q;
      if (pvalid_q) begin
        if (plast_q) begin
          acc_q   <= '0;
          dec_q   <= ~sum_d[ACC_W-1];
          above_q <= ({1'b0, mag_d} >= THR);
        end else begin
          acc_q <= sum_d;
        end
      end
    end
  end

  state_t           state_q;
  logic [RUN_W-1:0] run_q;
  logic             prev_q;
  logic             read_q;
  logic             clear_q;
  logic             data_q;
  logic             locked_q;

  // Stage 3: lock FSM. The dump that changes state emits no bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      run_q    <= '0;
      prev_q   <= 1'b0;
      read_q   <= 1'b0;
      clear_q  <= 1'b0;
      data_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      read_q  <= 1'b0;
      clear_q <= 1'b0;
      data_q  <= 1'b0;
      if (dump_q) begin
        prev_q <= dec_q;
        case (state_q)
          SEARCH: begin
            if (!above_q) begin
              run_q <= '0;
            end else if (run_q == LOCK_LAST) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end
          LOCKED: begin
            if (above_q) begin
              run_q  <= '0;
              read_q <= 1'b1;
              data_q <= dec_q ^ prev_q;
            end else if (run_q == LOSS_LAST) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              clear_q  <= 1'b1;
              run_q    <= '0;
            end else begin
              run_q  <= run_q + RUN_W'(1);
              read_q <= 1'b1;
              data_q <= dec_q ^ prev_q;
            end
          end
        endcase
      end
    end
  end

  assign data_stream = data_q;
  assign read        = read_q;
  assign clear       = clear_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed-symbol bench: the driver queues each expected read/clear/lock event
// with its due time, and a negedge monitor matches them as the DUT produces them.
module tb_bpsk_demodulator;

  localparam int P = 10;

  logic clk = 1'b0;
  logic reset;

  always #(P / 2) clk = ~clk;

  bpsk_demodulator_if bus ();

  bpsk_demodulator dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (bus.sample),
    .sample_valid (bus.sample_valid),
    .data_stream  (bus.data_stream),
    .read         (bus.read),
    .clear        (bus.clear),
    .locked       (bus.locked)
  );

  typedef enum int {EV_NONE, EV_READ, EV_CLEAR, EV_LOCK} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    logic     data;
    logic     lck;
    time      t;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  // 1000*sin(2*pi*k/16), rounded.
  int sine_tab [16] = '{0, 383, 707, 924, 1000, 924, 707, 383,
                        0, -383, -707, -924, -1000, -924, -707, -383};
  // Full-scale, opposite sign to the carrier (phase pi), clipped to 12-bit range.
  int full_tab [16] = '{0, -2048, -2048, -2048, -2048, -2048, -2048, -2048,
                        0, 2047, 2047, 2047, 2047, 2047, 2047, 2047};

  task automatic drive(input int s);
    @(negedge clk);
    bus.sample       = 12'(s);
    bus.sample_valid = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample       = 12'sh5A5;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
    end
  endtask

  // kind: 0 = 1000*sine, 1 = silence, 2 = full-scale pi. Event is due 3 periods
  // after the phase-15 sample is driven (accept edge + 2 cycles, seen at negedge).
  task automatic send_sym(input int kind, input bit flip, input bit gapped,
                          input ev_kind_t ek, input logic d);
    for (int k = 0; k < 16; k++) begin
      int s;
      case (kind)
        0:       s = sine_tab[k];
        1:       s = 0;
        default: s = full_tab[k];
      endcase
      if (flip) s = -s;
      drive(s);
      if (k == 15 && ek != EV_NONE)
        exp_q.push_back('{ek, d, (ek != EV_CLEAR), $time + 3 * P});
      if (gapped) gap();
    end
  endtask

  task automatic check_idle(input string nm);
    vectors++;
    if ({bus.data_stream, bus.read, bus.clear, bus.locked} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s outputs{data,read,clear,locked}=%b expected=0000", nm,
               {bus.data_stream, bus.read, bus.clear, bus.locked});
    end
  endtask

  initial begin : monitor
    logic lock_prev;
    lock_prev = 1'b0;
    forever begin
      ev_kind_t k;
      ev_t      e;
      @(negedge clk);
      k = EV_NONE;
      if (bus.clear === 1'b1)                          k = EV_CLEAR;
      else if (bus.read === 1'b1)                      k = EV_READ;
      else if (bus.locked === 1'b1 && lock_prev == 1'b0) k = EV_LOCK;
      lock_prev = (bus.locked === 1'b1);
      if (k != EV_NONE) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event kind=%s at t=%0t expected=no event", k.name(), $time);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.t != $time || bus.locked !== e.lck ||
              (k == EV_READ && bus.data_stream !== e.data)) begin
            miscompares++;
            $display("FAIL event kind=%s/%s t=%0t/%0t data=%b/%b locked=%b/%b (actual/expected)",
                     k.name(), e.kind.name(), $time, e.t, bus.data_stream, e.data,
                     bus.locked, e.lck);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset            = 1'b1;
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;

    // Acquire: eight strong phase-0 symbols, lock on the eighth, no reads.
    for (int i = 0; i < 7; i++) send_sym(0, 1'b0, 1'b0, EV_NONE, 1'b0);
    send_sym(0, 1'b0, 1'b0, EV_LOCK, 1'b0);

    // Phase flips pi, pi, 0 after the phase-0 lock symbol -> 1, 0, 1.
    send_sym(0, 1'b1, 1'b0, EV_READ, 1'b1);
    send_sym(0, 1'b1, 1'b0, EV_READ, 1'b0);
    send_sym(0, 1'b0, 1'b0, EV_READ, 1'b1);

    // Silence: three weak reads (0 >= 0 decides 1, same as previous), then loss.
    for (int i = 0; i < 3; i++) send_sym(1, 1'b0, 1'b0, EV_READ, 1'b0);
    send_sym(1, 1'b0, 1'b0, EV_CLEAR, 1'b0);
    idle(4);

    // Same sequence with a gap after every sample.
    for (int i = 0; i < 7; i++) send_sym(0, 1'b0, 1'b1, EV_NONE, 1'b0);
    send_sym(0, 1'b0, 1'b1, EV_LOCK, 1'b0);
    send_sym(0, 1'b1, 1'b1, EV_READ, 1'b1);
    send_sym(0, 1'b1, 1'b1, EV_READ, 1'b0);
    send_sym(0, 1'b0, 1'b1, EV_READ, 1'b1);
    idle(4);

    // Reset in the slot of phase 7 while locked.
    vectors++;
    if (bus.locked !== 1'b1) begin
      miscompares++;
      $display("FAIL locked_before_reset locked=%b expected=1", bus.locked);
    end
    for (int k = 0; k < 7; k++) drive(sine_tab[k]);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    reset            = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("after_mid_symbol_reset");

    // Full-scale pi symbols from phase 0: relock on the 8th, then eight 0 bits,
    // then a phase-0 symbol giving 1.
    for (int i = 0; i < 7; i++) send_sym(2, 1'b0, 1'b0, EV_NONE, 1'b0);
    send_sym(2, 1'b0, 1'b0, EV_LOCK, 1'b0);
    for (int i = 0; i < 8; i++) send_sym(2, 1'b0, 1'b0, EV_READ, 1'b0);
    send_sym(0, 1'b0, 1'b0, EV_READ, 1'b1);
    idle(8);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL events_drained pending=%0d expected=0 (next kind=%s due t=%0t)",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
